// File: rtl/system_0_sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and
// compares them against build-time values to accept or reject the FPGA image.
module system_0_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h639D1973,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h00000000,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  RETRY_LIMIT = 5'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    GAP,
    RD_TS,
    CHECK,
    FAIL
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic [4:0]  retry_cnt, retry_cnt_nxt;

  logic        avm_address_nxt, avm_read_nxt, busy_nxt, done_nxt;
  logic        pass_nxt, id_ok_nxt, ts_ok_nxt, timeout_nxt;
  logic [31:0] id_value_nxt, ts_value_nxt;

  logic        accepted, stalled, expired, retries_left;
  logic        id_match, ts_match;

  assign accepted     = avm_read & ~avm_waitrequest;
  assign stalled      = avm_read & avm_waitrequest;
  assign expired      = stalled && (wait_cnt == WAIT_LAST);
  assign retries_left = (retry_cnt < RETRY_LIMIT);
  assign id_match     = (id_value == EXPECTED_ID);
  assign ts_match     = (avm_readdata == EXPECTED_TIMESTAMP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      retry_cnt   <= '0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      retry_cnt   <= retry_cnt_nxt;
      avm_address <= avm_address_nxt;
      avm_read    <= avm_read_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pass        <= pass_nxt;
      id_ok       <= id_ok_nxt;
      ts_ok       <= ts_ok_nxt;
      timeout     <= timeout_nxt;
      id_value    <= id_value_nxt;
      ts_value    <= ts_value_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RD_ID;
      RD_ID: begin
        if (accepted)                     state_nxt = GAP;
        else if (expired && !retries_left) state_nxt = FAIL;
      end
      GAP:   state_nxt = RD_TS;
      RD_TS: begin
        if (accepted)                     state_nxt = CHECK;
        else if (expired && !retries_left) state_nxt = FAIL;
      end
      CHECK: state_nxt = IDLE;
      FAIL:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are registered on the edge that enters CHECK/FAIL so done and
  // pass are visible together in that state; everything else holds.
  always_comb begin
    wait_cnt_nxt    = wait_cnt;
    retry_cnt_nxt   = retry_cnt;
    avm_address_nxt = avm_address;
    avm_read_nxt    = avm_read;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
    pass_nxt        = pass;
    id_ok_nxt       = id_ok;
    ts_ok_nxt       = ts_ok;
    timeout_nxt     = timeout;
    id_value_nxt    = id_value;
    ts_value_nxt    = ts_value;

    case (state)
      IDLE: begin
        if (start) begin
          pass_nxt        = 1'b0;
          id_ok_nxt       = 1'b0;
          ts_ok_nxt       = 1'b0;
          timeout_nxt     = 1'b0;
          id_value_nxt    = '0;
          ts_value_nxt    = '0;
          wait_cnt_nxt    = '0;
          retry_cnt_nxt   = '0;
          avm_address_nxt = 1'b1;
          avm_read_nxt    = 1'b1;
          busy_nxt        = 1'b1;
        end
      end

      RD_ID, RD_TS: begin
        if (!avm_read) begin
          // One-cycle idle gap after a timed-out attempt; retry the same word.
          avm_read_nxt = 1'b1;
        end else if (accepted) begin
          avm_read_nxt = 1'b0;
          wait_cnt_nxt = '0;
          if (state == RD_ID) begin
            id_value_nxt = avm_readdata;
          end else begin
            ts_value_nxt = avm_readdata;
            id_ok_nxt    = id_match;
            ts_ok_nxt    = ts_match;
            pass_nxt     = id_match & (ts_match | ~CHECK_TIMESTAMP);
            done_nxt     = 1'b1;
            busy_nxt     = 1'b0;
          end
        end else if (expired) begin
          avm_read_nxt  = 1'b0;
          wait_cnt_nxt  = '0;
          retry_cnt_nxt = retry_cnt + 5'd1;
          if (!retries_left) begin
            timeout_nxt = 1'b1;
            pass_nxt    = 1'b0;
            done_nxt    = 1'b1;
            busy_nxt    = 1'b0;
          end
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end

      GAP: begin
        avm_address_nxt = 1'b0;
        avm_read_nxt    = 1'b1;
        wait_cnt_nxt    = '0;
        retry_cnt_nxt   = '0;
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// Scoreboard bench for the sysid checker: stimulus pushes expected results,
// per-DUT monitors pop and compare on every done pulse.
module tb_system_0_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h639D1973;

  typedef struct {
    int          done_cycle;
    logic        pass;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_a, start_b, wait_a, wait_b;
  logic [31:0] id_word, ts_word, rdata_a, rdata_b;

  logic        addr_a, read_a, busy_a, done_a, pass_a, id_ok_a, ts_ok_a, timeout_a;
  logic [31:0] id_value_a, ts_value_a;
  logic        addr_b, read_b, busy_b, done_b, pass_b, id_ok_b, ts_ok_b, timeout_b;
  logic [31:0] id_value_b, ts_value_b;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  system_0_sysid_checker dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .avm_address(addr_a), .avm_read(read_a),
    .avm_waitrequest(wait_a), .avm_readdata(rdata_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .id_ok(id_ok_a),
    .ts_ok(ts_ok_a), .timeout(timeout_a),
    .id_value(id_value_a), .ts_value(ts_value_a)
  );

  system_0_sysid_checker #(
    .CHECK_TIMESTAMP(1'b0),
    .TIMEOUT_CYCLES(4),
    .MAX_RETRIES(1)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .avm_address(addr_b), .avm_read(read_b),
    .avm_waitrequest(wait_b), .avm_readdata(rdata_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .id_ok(id_ok_b),
    .ts_ok(ts_ok_b), .timeout(timeout_b),
    .id_value(id_value_b), .ts_value(ts_value_b)
  );

  // Slave model: address 1 returns the ID word, address 0 the timestamp.
  assign rdata_a = addr_a ? id_word : ts_word;
  assign rdata_b = addr_b ? id_word : ts_word;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic compareResult(input string tag, input exp_t e,
                               input logic p, input logic io, input logic tso,
                               input logic tmo, input logic bsy,
                               input logic [31:0] iv, input logic [31:0] tv);
    checkOutput({tag, "_done_cycle"}, cyc, e.done_cycle);
    checkOutput({tag, "_pass"}, {31'd0, p}, {31'd0, e.pass});
    checkOutput({tag, "_id_ok"}, {31'd0, io}, {31'd0, e.id_ok});
    checkOutput({tag, "_ts_ok"}, {31'd0, tso}, {31'd0, e.ts_ok});
    checkOutput({tag, "_timeout"}, {31'd0, tmo}, {31'd0, e.timeout});
    checkOutput({tag, "_busy_at_done"}, {31'd0, bsy}, 32'd0);
    checkOutput({tag, "_id_value"}, iv, e.id_value);
    checkOutput({tag, "_ts_value"}, tv, e.ts_value);
  endtask

  always @(negedge clock) begin
    if (!reset && done_a) begin
      checkOutput("a_done_expected", {31'd0, q_a.size() != 0}, 32'd1);
      if (q_a.size() != 0)
        compareResult("a", q_a.pop_front(), pass_a, id_ok_a, ts_ok_a, timeout_a,
                      busy_a, id_value_a, ts_value_a);
    end
  end

  always @(negedge clock) begin
    if (!reset && done_b) begin
      checkOutput("b_done_expected", {31'd0, q_b.size() != 0}, 32'd1);
      if (q_b.size() != 0)
        compareResult("b", q_b.pop_front(), pass_b, id_ok_b, ts_ok_b, timeout_b,
                      busy_b, id_value_b, ts_value_b);
    end
  end

  task automatic applyStimulus(input bit use_b, input logic [31:0] id, input logic [31:0] ts,
                               input int latency, input logic p, input logic io,
                               input logic tso, input logic tmo,
                               input logic [31:0] iv, input logic [31:0] tv);
    exp_t e;
    @(posedge clock); #1;
    id_word      = id;
    ts_word      = ts;
    e.done_cycle = cyc + latency;
    e.pass       = p;
    e.id_ok      = io;
    e.ts_ok      = tso;
    e.timeout    = tmo;
    e.id_value   = iv;
    e.ts_value   = tv;
    if (use_b) begin
      q_b.push_back(e);
      start_b = 1'b1;
    end else begin
      q_a.push_back(e);
      start_a = 1'b1;
    end
    @(posedge clock); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 40 && (q_a.size() + q_b.size()) != 0; i++) @(posedge clock);
    checkOutput({name, "_drained"}, q_a.size() + q_b.size(), 32'd0);
    repeat (6) @(posedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] read_pat;
    int         addr_bad;
    exp_t       e;

    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    wait_a  = 1'b0;
    wait_b  = 1'b0;
    id_word = '0;
    ts_word = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_ctrl_a", {24'd0, addr_a, read_a, busy_a, done_a, pass_a, id_ok_a, ts_ok_a, timeout_a}, 32'd0);
    checkOutput("reset_ctrl_b", {24'd0, addr_b, read_b, busy_b, done_b, pass_b, id_ok_b, ts_ok_b, timeout_b}, 32'd0);
    checkOutput("reset_values_a", id_value_a | ts_value_a, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Matching image, zero-wait slave.
    applyStimulus(0, EXP_ID, 32'h0, 4, 1, 1, 1, 0, EXP_ID, 32'h0);
    waitDrain("match");

    // Wrong ID, then wrong timestamp with timestamp checking enabled.
    applyStimulus(0, 32'h12345678, 32'h0, 4, 0, 0, 1, 0, 32'h12345678, 32'h0);
    waitDrain("bad_id");
    applyStimulus(0, EXP_ID, 32'h5, 4, 0, 1, 0, 0, EXP_ID, 32'h5);
    waitDrain("bad_ts_checked");

    // Five stalled cycles on the ID read; request must hold steady.
    wait_a = 1'b1;
    applyStimulus(0, EXP_ID, 32'h0, 9, 1, 1, 1, 0, EXP_ID, 32'h0);
    addr_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (!(addr_a && read_a)) addr_bad++;
      @(posedge clock);
    end
    #1 wait_a = 1'b0;
    checkOutput("stall_hold", addr_bad, 32'd0);
    waitDrain("stall");

    // Reset while the timestamp read is in flight.
    @(posedge clock); #1;
    id_word = EXP_ID;
    ts_word = 32'h0;
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("in_rd_ts", {30'd0, addr_a, read_a}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid_reset_ctrl", {27'd0, read_a, busy_a, pass_a, done_a, timeout_a}, 32'd0);
    checkOutput("mid_reset_id_value", id_value_a, 32'd0);
    reset = 1'b0;
    applyStimulus(0, EXP_ID, 32'h0, 4, 1, 1, 1, 0, EXP_ID, 32'h0);
    waitDrain("after_reset");

    // Start held through cycles 1-2 and pulsed again in the done cycle.
    @(posedge clock); #1;
    id_word      = EXP_ID;
    ts_word      = 32'h0;
    e.done_cycle = cyc + 4;
    e.pass       = 1'b1;
    e.id_ok      = 1'b1;
    e.ts_ok      = 1'b1;
    e.timeout    = 1'b0;
    e.id_value   = EXP_ID;
    e.ts_value   = 32'h0;
    q_a.push_back(e);
    start_a = 1'b1;
    repeat (3) @(posedge clock);
    #1 start_a = 1'b0;
    @(posedge clock); #1;
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    waitDrain("start_busy");

    // Timestamp ignored on dut_b.
    applyStimulus(1, EXP_ID, 32'h5, 4, 1, 1, 0, 0, EXP_ID, 32'h5);
    waitDrain("ts_unchecked");

    // Stuck waitrequest: 4-cycle attempt, gap, 4-cycle retry, then timeout.
    wait_b = 1'b1;
    applyStimulus(1, EXP_ID, 32'h0, 10, 0, 0, 0, 1, 32'h0, 32'h0);
    addr_bad = 0;
    read_pat = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      read_pat[9 - i] = read_b;
      if (read_b && !addr_b) addr_bad++;
    end
    wait_b = 1'b0;
    checkOutput("retry_read_pattern", {22'd0, read_pat}, {22'd0, 10'b1111011110});
    checkOutput("retry_addr_hold", addr_bad, 32'd0);
    waitDrain("timeout");

    // Next check after a timeout starts clean.
    applyStimulus(1, EXP_ID, 32'h0, 4, 1, 1, 1, 0, EXP_ID, 32'h0);
    waitDrain("after_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/system_0_sysid_checker.md
Name: system_0_sysid_checker

Overview:
Avalon-MM read master that runs at the initiator end of the system-ID slave interface. When started, it reads the ID word at address 1 and the timestamp word at address 0, then compares both against build-time expected values. It reports pass/fail, captured values and timeout status, so boot logic or a debug LED can reject a mismatched FPGA image before software runs.

Parameters:
EXPECTED_ID, 32'h639D1973 (1671240051), system ID word the slave must return at address 1
EXPECTED_TIMESTAMP, 32'h00000000, timestamp word the slave must return at address 0
CHECK_TIMESTAMP, 1, 1 = timestamp mismatch fails the check; 0 = timestamp is captured only
TIMEOUT_CYCLES, 255, maximum waitrequest-stalled cycles per read attempt (1..65535)
MAX_RETRIES, 3, extra attempts per read after a timeout (0..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a check; ignored while busy=1
avm_address  out  1  Avalon-MM word address: 1 = ID, 0 = timestamp
avm_read  out  1  Avalon-MM read strobe
avm_waitrequest  in  1  slave stall; tie to 0 for a zero-wait slave
avm_readdata  in  32  read data, valid in the cycle where avm_read=1 and avm_waitrequest=0
busy  out  1  check in progress
done  out  1  one-cycle pulse when the check completes
pass  out  1  sticky result: 1 = all enabled compares matched and no timeout
id_ok  out  1  captured ID == EXPECTED_ID
ts_ok  out  1  captured timestamp == EXPECTED_TIMESTAMP
timeout  out  1  a read exhausted all of its retries
id_value  out  32  captured ID word
ts_value  out  32  captured timestamp word

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). All outputs are registered.
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, pass=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, FSM=IDLE, all counters 0.
- FSM states:
  - IDLE: start=1 -> clear pass/id_ok/ts_ok/timeout/id_value/ts_value and the retry counter; set avm_address=1, avm_read=1, busy=1; go to RD_ID.
  - RD_ID: avm_waitrequest=0 -> latch avm_readdata into id_value; drop avm_read for one cycle; go to GAP.
  - GAP: set avm_address=0, avm_read=1; clear the wait and retry counters; go to RD_TS. This state guarantees avm_read is low for one cycle between transfers.
  - RD_TS: avm_waitrequest=0 -> latch ts_value; avm_read=0; go to CHECK.
  - CHECK: set id_ok, ts_ok and pass = id_ok & (ts_ok | ~CHECK_TIMESTAMP); done=1 for one cycle; busy=0; go to IDLE.
- Stall handling in RD_ID/RD_TS:
  - The wait counter increments each cycle that waitrequest=1.
  - When the counter reaches TIMEOUT_CYCLES with waitrequest still 1: deassert avm_read for one cycle and increment the retry counter. If retries <= MAX_RETRIES, reassert the same read; otherwise set timeout=1 and go to a FAIL step: pass=0, done pulse, busy=0, return to IDLE.
  - A captured value from a read that timed out is not latched (it keeps its cleared value 0).
  - avm_address and avm_read stay constant while waitrequest=1 (Avalon hold rule).
- Latency with zero-wait slave: start at cycle 0 -> ID read cycle 1, GAP cycle 2, TS read cycle 3, done/pass valid at cycle 4 (done high during cycle 4). Result outputs hold until the next start.
- start during busy: ignored, no queueing. start in the same cycle as done: ignored (FSM is not in IDLE yet).
- reset mid-operation: all outputs are forced to reset values on the next edge; avm_read drops immediately; no partial result is reported.
- Compares are full 32-bit equality; no masking.

Test Plan:
- Zero-wait slave returning 0x639D1973 @1 and 0x00000000 @0; start pulse -> done at cycle 4, pass=1, id_ok=1, ts_ok=1, id_value=0x639D1973.
- Slave returns 0x12345678 @1 -> pass=0, id_ok=0, ts_ok=1, id_value=0x12345678. Repeat with timestamp 0x5 and CHECK_TIMESTAMP=0 -> pass=1, ts_ok=0.
- waitrequest held 5 cycles on the ID read -> avm_address/avm_read stable throughout, done at cycle 9, pass=1.
- TIMEOUT_CYCLES=4, MAX_RETRIES=1, waitrequest stuck at 1 -> two read attempts with a one-cycle read gap between them, then timeout=1, pass=0, done pulse, busy=0.
- reset asserted in RD_TS -> next cycle avm_read=0, busy=0, pass=0, id_value=0. A following start runs a clean check that passes.
- start pulsed again at cycles 1 and 2 of a check -> ignored; exactly one done pulse is produced.
